// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - ID/EX issue stage signal bundle: ID fields, forward sources, ALU-side outputs
interface alu_issue_stage_if;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dest;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        id_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dest;
  logic [31:0] exmem_data;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_data;
  logic [31:0] ALU_in1;
  logic [31:0] ALU_in2;
  logic [3:0]  ALU_control;
  logic        ex_valid;
  logic        ex_reg_write;
  logic [4:0]  ex_dest;
  logic [31:0] ex_store_data;
  logic        illegal_op;

  modport master (
    output id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt, id_dest,
           id_rs_data, id_rt_data, id_imm, id_reg_write,
           exmem_reg_write, exmem_dest, exmem_data,
           memwb_reg_write, memwb_dest, memwb_data,
    input  ALU_in1, ALU_in2, ALU_control, ex_valid, ex_reg_write, ex_dest,
           ex_store_data, illegal_op
  );

  modport slave (
    input  id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt, id_dest,
           id_rs_data, id_rt_data, id_imm, id_reg_write,
           exmem_reg_write, exmem_dest, exmem_data,
           memwb_reg_write, memwb_dest, memwb_data,
    output ALU_in1, ALU_in2, ALU_control, ex_valid, ex_reg_write, ex_dest,
           ex_store_data, illegal_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX register with ALU control decode, operand forwarding, stall and flush
module alu_issue_stage (
  input logic              clk,
  input logic              reset,
  input logic              stall,
  input logic              flush,
  alu_issue_stage_if.slave bus
);
  logic        valid_q;
  logic        reg_write_q;
  logic        illegal_q;
  logic        alu_src_q;
  logic [3:0]  ctrl_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  dest_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;

  logic [3:0]  dec_ctrl;
  logic        dec_illegal;
  logic        load_bubble;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  always_comb begin
    dec_ctrl    = 4'b0010;
    dec_illegal = 1'b0;
    case (bus.id_alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0001;
      default: begin
        case (bus.id_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          6'b100111: dec_ctrl = 4'b1100;
          default:   dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // An idle ID slot is captured exactly like a flush so the EX side sees a clean bubble.
  assign load_bubble = reset || flush || (!stall && !bus.id_valid);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      ctrl_q      <= 4'b0000;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      dest_q      <= 5'd0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      imm_q       <= 32'd0;
    end else if (!stall) begin
      valid_q     <= 1'b1;
      reg_write_q <= bus.id_reg_write;
      illegal_q   <= dec_illegal;
      alu_src_q   <= bus.id_alu_src;
      ctrl_q      <= dec_ctrl;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      dest_q      <= bus.id_dest;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
    end
  end

  // EX/MEM is checked first because it carries the younger write to the same register.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && bus.exmem_dest != 5'd0 && bus.exmem_dest == rs_q)
      fwd_rs = bus.exmem_data;
    else if (bus.memwb_reg_write && bus.memwb_dest != 5'd0 && bus.memwb_dest == rs_q)
      fwd_rs = bus.memwb_data;

    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && bus.exmem_dest != 5'd0 && bus.exmem_dest == rt_q)
      fwd_rt = bus.exmem_data;
    else if (bus.memwb_reg_write && bus.memwb_dest != 5'd0 && bus.memwb_dest == rt_q)
      fwd_rt = bus.memwb_data;
  end

  assign bus.ALU_in1       = fwd_rs;
  assign bus.ALU_in2       = alu_src_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ALU_control   = ctrl_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_dest       = dest_q;
  assign bus.ex_reg_write  = reg_write_q && valid_q && !illegal_q;
  assign bus.illegal_op    = illegal_q && valid_q;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline register and operand issue logic that drives the ALU's operand and control inputs: `ALU_in1`, `ALU_in2` and the 4-bit `ALU_control`. It captures decoded instruction fields from ID and translates ALUOp/funct into the ALU control code. It also applies EX/MEM and MEM/WB forwarding to the registered source operands and handles stall and flush, so the combinational ALU sees a clean, hazard-resolved operation every cycle.

## Interface
No parameters; all widths are fixed by the MIPS datapath.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold all stage registers.
- `flush` in 1: load a bubble; has priority over `stall`.
- `id_valid` in 1: ID holds a real instruction.
- `id_alu_op` in 2: main-control ALUOp.
- `id_funct` in 6: instruction[5:0].
- `id_alu_src` in 1: 1 selects the immediate for operand 2.
- `id_rs`, `id_rt`, `id_dest` in 5 each: source and destination register numbers.
- `id_rs_data`, `id_rt_data` in 32 each: register-file read data.
- `id_imm` in 32: immediate, already sign- or zero-extended.
- `id_reg_write` in 1: instruction writes `id_dest`.
- `exmem_reg_write` in 1, `exmem_dest` in 5, `exmem_data` in 32: EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_dest` in 5, `memwb_data` in 32: MEM/WB forward source.
- `ALU_in1` out 32: ALU operand 1.
- `ALU_in2` out 32: ALU operand 2.
- `ALU_control` out 4: ALU operation code.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_reg_write` out 1, `ex_dest` out 5: passed to EX/MEM.
- `ex_store_data` out 32: forwarded rt value, used by stores.
- `illegal_op` out 1: the registered instruction has an undecodable funct.

## Operation
**Stage register update, on each rising `clk`, first matching condition wins:**
- `reset`: all stage registers cleared to 0.
- `flush`: `valid_q`, `reg_write_q` and `illegal_q` set to 0, and `ctrl_q` set to 4'b0000. The data and register-number fields are cleared to 0.
- `stall`: all stage registers hold their values.
- Otherwise: capture all `id_*` fields and decode the control code into `ctrl_q`. If `id_valid` is 0, capture as for flush.

**Decode (registered into `ctrl_q`):**
- ALUOp 00 → 0010 (add).
- ALUOp 01 → 0110 (sub).
- ALUOp 11 → 0001 (or; used for ori).
- ALUOp 10 decodes funct:
  - 100000 → 0010 (add)
  - 100010 → 0110 (sub)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
  - 101010 → 0111 (slt)
  - 100111 → 1100 (nor)
  - any other funct → 0010, and `illegal_q` = 1.

**Forwarding (combinational from the stage registers and the forward inputs):**
- The forwarded rs value is `exmem_data` if `exmem_reg_write` is set, `exmem_dest` ≠ 0 and `exmem_dest` == `rs_q`.
- Otherwise it is `memwb_data` under the same three conditions applied to the MEM/WB fields.
- Otherwise it is `rs_data_q`.
- The forwarded rt value uses the same rule with `rt_q` and `rt_data_q`.
- EX/MEM always beats MEM/WB. Register 0 is never forwarded.

**Outputs:**
- `ALU_in1` = forwarded rs.
- `ALU_in2` = `imm_q` if `alu_src_q` is 1, else forwarded rt.
- `ex_store_data` = forwarded rt in every case.
- `ALU_control` = `ctrl_q`, `ex_valid` = `valid_q`, `ex_dest` = `dest_q`.
- `ex_reg_write` = `reg_write_q` AND `valid_q` AND NOT `illegal_q`.
- `illegal_op` = `illegal_q` AND `valid_q`.
- A bubble presents operands 0/0 with control 0000, so the ALU result is 0 and Zero = 1. Downstream logic must gate on `ex_valid`.

## Timing
- Exactly one cycle of latency from the `id_*` inputs to the registered outputs. Forwarding adds no cycle: it is a same-cycle mux on the registered values.
- Reset values: `ALU_in1` = 0, `ALU_in2` = 0, `ALU_control` = 0000, `ex_valid` = 0, `ex_reg_write` = 0, `ex_dest` = 0, `ex_store_data` = 0, `illegal_op` = 0. These hold regardless of the forward inputs, because `rs_q` and `rt_q` are 0.
- `stall` and `flush` asserted together: the flush happens.
- `reset` together with `flush` or `stall`: the reset happens.
- Reset asserted while an instruction is in the stage discards that instruction in the same edge. No partial state survives.
- While stalled, the outputs can still change if the forward inputs change, because forwarding remains live. This is required: MEM/WB data must reach a stalled instruction.
- Both forward sources matching the same register: EX/MEM wins (it holds the newer value).

## Test plan
1. **Reset:** `reset` = 1 with `exmem_reg_write` = 1, `exmem_dest` = 0, `exmem_data` = 0xFFFFFFFF → the cycle after reset, every output is 0 and `ALU_control` = 0000.
2. **R-type decode:** ALUOp = 10, apply each funct 0x20, 0x22, 0x24, 0x25, 0x2A, 0x27 on successive cycles → one cycle later `ALU_control` = 0010, 0110, 0000, 0001, 0111, 1100. Then funct 0x03 → `ALU_control` = 0010, `illegal_op` = 1, `ex_reg_write` = 0.
3. **Forwarding priority:** `id_rs` = 5, `rs_data` = 1. Drive `exmem_dest` = 5 with data 0xAAAA and `memwb_dest` = 5 with data 0xBBBB → `ALU_in1` = 0xAAAA. Drop `exmem_reg_write` → `ALU_in1` = 0xBBBB. Set `id_rs` = 0 → `ALU_in1` = `rs_data_q` with no forwarding.
4. **Immediate select:** `id_alu_src` = 1, `id_imm` = 0xFFFFFFFC, rt forwarded to 0x1234 → `ALU_in2` = 0xFFFFFFFC and `ex_store_data` = 0x1234.
5. **Stall then flush:** load an add, then hold `stall` for 3 cycles while presenting a sub → add outputs stay constant for all 3 cycles. Then assert `stall` and `flush` together → `ex_valid` = 0, `ALU_control` = 0000, `ALU_in1` = 0, `ALU_in2` = 0.
6. **Reset mid-stream:** valid instructions on consecutive cycles, with `reset` = 1 for one cycle → the next cycle `ex_valid` = 0, and the instruction presented after reset is released captures normally one cycle later.
